// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_t : controller FSM states (RUN, MEM_WAIT, REDIRECT)
//   PRI_*      : hazard cause encoding, ordered so a larger value wins
//   hz_pri     : picks the winning cause from the raw hazard conditions
package pipeline_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  typedef enum logic [1:0] {
    RUN      = ST_RUN,
    MEM_WAIT = ST_MEM_WAIT,
    REDIRECT = ST_REDIRECT
  } hz_state_t;

  localparam logic [1:0] PRI_NONE     = 2'd0;
  localparam logic [1:0] PRI_LOAD_USE = 2'd1;
  localparam logic [1:0] PRI_BRANCH   = 2'd2;
  localparam logic [1:0] PRI_MEM      = 2'd3;

  // Memory stall beats a taken branch, which beats a load-use bubble.
  function automatic logic [1:0] hz_pri(input logic mem, input logic br, input logic lu);
    if (mem)     return PRI_MEM;
    else if (br) return PRI_BRANCH;
    else if (lu) return PRI_LOAD_USE;
    else         return PRI_NONE;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID-stage instruction that reads the
// destination of a load still sitting in ID/EX. Register 0 never matches.
//   rs1, rs2          : ID-stage source register IDs
//   uses_rs1, uses_rs2: the corresponding source is really read
//   ex_dest           : destination register in ID/EX
//   ex_mem_read       : ID/EX instruction is a load
//   hit               : load-use hazard present
module load_use_detect #(
  parameter int REG_ID_WIDTH = 5
) (
  input  logic [REG_ID_WIDTH-1:0] rs1,
  input  logic [REG_ID_WIDTH-1:0] rs2,
  input  logic                    uses_rs1,
  input  logic                    uses_rs2,
  input  logic [REG_ID_WIDTH-1:0] ex_dest,
  input  logic                    ex_mem_read,
  output logic                    hit
);

  logic dest_nz;
  logic m1, m2;

  assign dest_nz = (ex_dest != '0);
  assign m1      = uses_rs1 && (rs1 == ex_dest);
  assign m2      = uses_rs2 && (rs2 == ex_dest);
  assign hit     = ex_mem_read && dest_nz && (m1 || m2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: generates per-register stall/flush controls
// and the PC redirect select for a 5-stage pipeline.
//   clk, reset (sync, active-high)
//   id_rs1/id_rs2/id_uses_rs1/id_uses_rs2 : ID-stage source operands
//   ex_dest/ex_mem_read                   : load in ID/EX
//   branch_taken                          : branch outcome from EX/MEM
//   dmem_req/dmem_ready                   : data-memory handshake
//   stall_pc, stall_if_id..stall_mem_wb   : register holds
//   flush_if_id, flush_id_ex, flush_ex_mem: bubble insertion
//   pc_redirect                           : PC takes the branch target
// Optional feature, macro PIPELINE_HAZARD_PERF_EN: saturating stall_cnt /
// flush_cnt performance counters (ports present only when defined).
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ID_WIDTH = 5,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [REG_ID_WIDTH-1:0] id_rs1,
  input  logic [REG_ID_WIDTH-1:0] id_rs2,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  logic [REG_ID_WIDTH-1:0] ex_dest,
  input  logic                    ex_mem_read,
  input  logic                    branch_taken,
  input  logic                    dmem_req,
  input  logic                    dmem_ready,
  output logic                    stall_pc,
  output logic                    stall_if_id,
  output logic                    stall_id_ex,
  output logic                    stall_ex_mem,
  output logic                    stall_mem_wb,
  output logic                    flush_if_id,
  output logic                    flush_id_ex,
  output logic                    flush_ex_mem,
  output logic                    pc_redirect
`ifdef PIPELINE_HAZARD_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]    stall_cnt,
  output logic [CNT_WIDTH-1:0]    flush_cnt
`endif
);

  hz_state_t  state, state_nxt;
  logic [1:0] pri;
  logic       mem_stall;
  logic       lu_hit;

  assign mem_stall = dmem_req && !dmem_ready;

  load_use_detect #(.REG_ID_WIDTH(REG_ID_WIDTH)) u_lu (
    .rs1         (id_rs1),
    .rs2         (id_rs2),
    .uses_rs1    (id_uses_rs1),
    .uses_rs2    (id_uses_rs2),
    .ex_dest     (ex_dest),
    .ex_mem_read (ex_mem_read),
    .hit         (lu_hit)
  );

  // Winning hazard cause for this cycle. MEM_WAIT only watches dmem_ready;
  // a branch held in EX/MEM is picked up in the following RUN cycle.
  // REDIRECT masks branch and load-use because those instructions were
  // just flushed.
  always_comb begin
    pri = PRI_NONE;
    case (state)
      RUN:      pri = hz_pri(mem_stall, branch_taken, lu_hit);
      MEM_WAIT: pri = dmem_ready ? PRI_NONE : PRI_MEM;
      REDIRECT: pri = hz_pri(mem_stall, 1'b0, 1'b0);
      default:  pri = PRI_NONE;
    endcase
    // Quiet outputs while reset is held so nothing leaks from the old state.
    if (reset) pri = PRI_NONE;
  end

  always_comb begin
    case (pri)
      PRI_MEM:    state_nxt = MEM_WAIT;
      PRI_BRANCH: state_nxt = REDIRECT;
      default:    state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    pc_redirect  = 1'b0;
    case (pri)
      PRI_MEM: begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        stall_mem_wb = 1'b1;
      end
      PRI_BRANCH: begin
        pc_redirect  = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
      end
      PRI_LOAD_USE: begin
        // Hold PC and IF/ID, push a bubble into ID/EX.
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PIPELINE_HAZARD_PERF_EN
  logic any_flush;
  assign any_flush = flush_if_id || flush_id_ex || flush_ex_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_pc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (any_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  logic [CNT_WIDTH-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
